// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D).
// One access in flight at a time; ties between I and D alternate by last grant.
module cpu_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_read,
    input  logic [31:0] inst_address,
    output logic [31:0] inst_rdata,
    output logic        inst_resp,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_wmask,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [3:0]  mem_wmask_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_wdata_q;

    logic        inst_pend;
    logic        data_pend;
    logic        grant_d;

    assign inst_pend = inst_read;
    assign data_pend = data_read | data_write;

    // grant_d: 1 selects D, 0 selects I; on a tie the side not granted last wins
    always_comb begin
        grant_d = data_pend;
        if (inst_pend && data_pend) begin
            grant_d = ~last_grant_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wmask_q   <= 4'h0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_pend || data_pend) begin
                        last_grant_q <= grant_d;
                        if (grant_d) begin
                            // A simultaneous read+write request is served as a write
                            state_q       <= SERVE_D;
                            mem_read_q    <= ~data_write;
                            mem_write_q   <= data_write;
                            mem_wmask_q   <= data_wmask;
                            mem_address_q <= data_address;
                            mem_wdata_q   <= data_wdata;
                        end else begin
                            state_q       <= SERVE_I;
                            mem_read_q    <= 1'b1;
                            mem_write_q   <= 1'b0;
                            mem_wmask_q   <= 4'h0;
                            mem_address_q <= inst_address;
                            mem_wdata_q   <= 32'h0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

    // Responses are steered straight from the memory handshake in the serving state
    assign inst_resp  = (state_q == SERVE_I) && mem_resp;
    assign data_resp  = (state_q == SERVE_D) && mem_resp;
    assign inst_rdata = inst_resp ? mem_rdata : 32'h0;
    assign data_rdata = data_resp ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration rules.
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_read;
    logic [31:0] inst_address;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_wmask;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    cpu_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_read    (inst_read),
        .inst_address (inst_address),
        .inst_rdata   (inst_rdata),
        .inst_resp    (inst_resp),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_wmask   (data_wmask),
        .data_address (data_address),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_resp    (data_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model: is an access outstanding, who owns it, what was captured
    bit          m_busy;
    bit          m_owner;   // 0 = I, 1 = D
    bit          m_last;    // side granted most recently, 0 = I, 1 = D
    bit          m_rd;
    bit          m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    int          m_dly;
    bit          m_done_i;
    bit          m_done_d;
    bit          obs[$];    // owner of each response seen on the DUT outputs

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 0;
        m_rd    = 0;
        m_wr    = 0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_wmask = 4'h0;
        m_dly   = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_read"},   32'(mem_read),    32'h0);
        chk({tag, "_mem_write"},  32'(mem_write),   32'h0);
        chk({tag, "_mem_wmask"},  32'(mem_wmask),   32'h0);
        chk({tag, "_mem_addr"},   mem_address,      32'h0);
        chk({tag, "_mem_wdata"},  mem_wdata,        32'h0);
        chk({tag, "_inst_resp"},  32'(inst_resp),   32'h0);
        chk({tag, "_data_resp"},  32'(data_resp),   32'h0);
        chk({tag, "_inst_rdata"}, inst_rdata,       32'h0);
        chk({tag, "_data_rdata"}, data_rdata,       32'h0);
    endtask

    // Called just after a rising edge with inputs already driven for this cycle.
    task automatic step();
        logic exp_ir;
        logic exp_dr;
        bit   ri;
        bit   rd;
        @(negedge clk);
        exp_ir = m_busy && !m_owner && mem_resp;
        exp_dr = m_busy &&  m_owner && mem_resp;
        chk("inst_resp",  32'(inst_resp), 32'(exp_ir));
        chk("data_resp",  32'(data_resp), 32'(exp_dr));
        chk("inst_rdata", inst_rdata, exp_ir ? mem_rdata : 32'h0);
        chk("data_rdata", data_rdata, exp_dr ? mem_rdata : 32'h0);
        chk("mem_read",   32'(mem_read),  32'(m_busy && m_rd));
        chk("mem_write",  32'(mem_write), 32'(m_busy && m_wr));
        if (m_busy) begin
            chk("mem_address", mem_address,      m_addr);
            chk("mem_wdata",   mem_wdata,        m_wdata);
            chk("mem_wmask",   32'(mem_wmask),   32'(m_wmask));
        end
        if (inst_resp) obs.push_back(1'b0);
        if (data_resp) obs.push_back(1'b1);
        m_done_i = 0;
        m_done_d = 0;
        @(posedge clk);
        if (m_busy) begin
            if (mem_resp) begin
                m_busy = 0;
                if (m_owner) m_done_d = 1;
                else         m_done_i = 1;
            end
        end else begin
            ri = inst_read;
            rd = data_read || data_write;
            if (ri || rd) begin
                m_owner = (ri && rd) ? !m_last : rd;
                m_last  = m_owner;
                m_busy  = 1;
                m_dly   = $urandom_range(0, 2);
                if (m_owner) begin
                    m_wr    = data_write;
                    m_rd    = !data_write;
                    m_addr  = data_address;
                    m_wdata = data_wdata;
                    m_wmask = data_wmask;
                end else begin
                    m_wr    = 0;
                    m_rd    = 1;
                    m_addr  = inst_address;
                    m_wdata = 32'h0;
                    m_wmask = 4'h0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic drive_random();
        int kind;
        if (m_done_i) begin
            inst_read    = 1'($urandom_range(0, 1));
            inst_address = $urandom;
        end else if (!inst_read && $urandom_range(0, 3) == 0) begin
            inst_read    = 1'b1;
            inst_address = $urandom;
        end else if (inst_read && m_busy && !m_owner && $urandom_range(0, 1) == 1) begin
            inst_address = $urandom;
        end
        if (m_done_d || (!data_read && !data_write && $urandom_range(0, 3) == 0)) begin
            kind = $urandom_range(0, 3);
            data_read    = (kind == 0) || (kind == 2);
            data_write   = (kind == 1) || (kind == 2);
            data_address = $urandom;
            data_wdata   = $urandom;
            data_wmask   = 4'($urandom_range(0, 15));
        end else if ((data_read || data_write) && m_busy && m_owner && $urandom_range(0, 1) == 1) begin
            data_address = $urandom;
            data_wdata   = $urandom;
            data_wmask   = 4'($urandom_range(0, 15));
        end
        if (m_busy) begin
            mem_resp = (m_dly == 0);
            if (m_dly != 0) m_dly--;
        end else begin
            mem_resp = ($urandom_range(0, 7) == 0);
        end
        mem_rdata = $urandom;
    endtask

    bit exp_ord[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n        = 1'b0;
        inst_read    = 1'b0;
        inst_address = 32'h0;
        data_read    = 1'b0;
        data_write   = 1'b0;
        data_wmask   = 4'h0;
        data_address = 32'h0;
        data_wdata   = 32'h0;
        mem_rdata    = 32'hFFFF_FFFF;
        mem_resp     = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        mem_resp = 1'b0;
        rst_n    = 1'b1;

        // Lone fetch, address moves to 0x64 mid-access, response two cycles after mem_read
        inst_read    = 1'b1;
        inst_address = 32'h60;
        step();
        inst_address = 32'h64;
        step();
        mem_resp  = 1'b1;
        mem_rdata = 32'h00A0_0093;
        step();
        chk("fetch_done", 32'(m_done_i), 32'h1);
        inst_read = 1'b0;
        mem_resp  = 1'b0;
        step();

        // Lone store
        data_write   = 1'b1;
        data_address = 32'h104;
        data_wdata   = 32'hDEAD_BEEF;
        data_wmask   = 4'b0011;
        step();
        chk("store_wmask", 32'(mem_wmask), 32'h3);
        mem_resp = 1'b1;
        step();
        data_write = 1'b0;
        mem_resp   = 1'b0;
        step();

        // Read and write both high is served as a write
        data_read    = 1'b1;
        data_write   = 1'b1;
        data_address = 32'h200;
        data_wdata   = 32'h1234_5678;
        data_wmask   = 4'hF;
        step();
        chk("both_is_write", {30'h0, mem_read, mem_write}, 32'h1);
        mem_resp = 1'b1;
        step();
        data_read  = 1'b0;
        data_write = 1'b0;

        // Spurious responses while idle
        repeat (3) step();
        mem_resp = 1'b0;

        // Ties after reset alternate D, I, D, I
        do_reset();
        obs.delete();
        inst_read    = 1'b1;
        data_read    = 1'b1;
        inst_address = 32'h300;
        data_address = 32'h400;
        mem_resp     = 1'b1;
        repeat (8) step();
        inst_read = 1'b0;
        data_read = 1'b0;
        mem_resp  = 1'b0;
        step();
        chk("tie_count", 32'(obs.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs.size()) chk($sformatf("tie_order%0d", k), 32'(obs[k]), 32'(exp_ord[k]));
        end

        // Reset during SERVE_D with a response pending
        data_read    = 1'b1;
        data_address = 32'h500;
        step();
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFE_0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("rst_mid_edge");
        rst_n     = 1'b1;
        data_read = 1'b1;
        inst_read = 1'b1;
        obs.delete();
        step();
        step();
        chk("post_rst_first", 32'(obs.size() > 0 ? obs[0] : 1'b0), 32'h1);
        inst_read = 1'b0;
        data_read = 1'b0;
        mem_resp  = 1'b0;
        step();

        // Randomized traffic
        repeat (3000) begin
            drive_random();
            step();
            chk("resp_excl",   32'(inst_resp & data_resp), 32'h0);
            chk("strobe_excl", 32'(mem_read & mem_write),  32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Two-requester arbiter that shares one physical memory port between the pipeline's instruction-fetch side (port a) and data-memory side (port b). It sits between the pipelined datapath's split `address_a`/`address_b` interfaces and a single unified memory or cache. It sequences one access at a time with a three-state FSM and round-robin priority when both sides request. It steers the response and read data back to the owning requester.

## Interface
- No parameters; widths are fixed at 32-bit address/data and a 4-bit byte mask.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inst_read` in 1: instruction-fetch read request (level, held until `inst_resp`).
- `inst_address` in 32: fetch address, stable while `inst_read` is high.
- `inst_rdata` out 32: fetched word, valid only while `inst_resp` = 1.
- `inst_resp` out 1: fetch complete, one-cycle pulse.
- `data_read` in 1: data read request (level).
- `data_write` in 1: data write request (level).
- `data_wmask` in 4: byte enables for writes.
- `data_address` in 32: data address.
- `data_wdata` in 32: store data.
- `data_rdata` out 32: load word, valid only while `data_resp` = 1.
- `data_resp` out 1: data access complete, one-cycle pulse.
- `mem_read` out 1: downstream read strobe (registered).
- `mem_write` out 1: downstream write strobe (registered).
- `mem_wmask` out 4: downstream byte mask (registered).
- `mem_address` out 32: downstream address (registered).
- `mem_wdata` out 32: downstream write data (registered).
- `mem_rdata` in 32: downstream read data.
- `mem_resp` in 1: downstream completion, one cycle per access.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. `last_grant` is a 1-bit register: 0 = I, 1 = D.
- IDLE:
  - No request pending: stay in IDLE.
  - Only I pending (`inst_read` = 1): capture I's address, set `mem_read` = 1, go to SERVE_I.
  - Only D pending (`data_read` or `data_write` = 1): capture D's address, wdata and wmask, set the matching strobe, go to SERVE_D.
  - Both pending: grant the side not equal to `last_grant`.
  - `last_grant` updates on every grant.
- D side with `data_read` = `data_write` = 1 is treated as a write: `mem_write` = 1, `mem_read` = 0.
- For an I grant, `mem_wmask` = 0 and `mem_wdata` = 0.
- SERVE_x: hold all `mem_*` outputs constant until `mem_resp` = 1. In that cycle:
  - Combinationally assert the owner's `*_resp` = 1.
  - Pass `mem_rdata` to the owner's `*_rdata`. The non-owner's rdata is 0.
  - At the next edge, clear `mem_read`/`mem_write` and return to IDLE.
- `mem_resp` in IDLE is ignored: no resp output, no state change.
- Requester changes (address, or dropping the request) while in SERVE_x do not affect the in-flight access, because the captured registers are used.
- The request level is re-sampled in the IDLE cycle after a response. A still-high `inst_read` (always-on fetch) counts as a new request.

## Timing
- Reset (async assert):
  - state = IDLE, `last_grant` = 0 (so D wins the first tie).
  - `mem_read` = `mem_write` = 0; `mem_wmask`, `mem_address`, `mem_wdata` = 0.
  - `inst_resp` = `data_resp` = 0; both rdata outputs = 0.
- Reset asserted mid-access abandons the access immediately. No resp is issued, and a pending `mem_resp` is ignored. Release is synchronous to the next `clk` edge.
- Latency:
  - Request seen in IDLE at cycle N: `mem_*` strobe valid from cycle N+1.
  - Earliest `mem_resp`/`*_resp` is cycle N+1; IDLE is re-entered at N+2.
  - Minimum 2 cycles per access; back-to-back grants every 2 cycles minimum.
- Strobes never assert for both sides in the same cycle. `inst_resp` and `data_resp` are mutually exclusive.

## Test plan
- Lone fetch:
  - Stimulus: `inst_read` = 1, `inst_address` = 0x60; memory responds with 0x00A00093 two cycles after `mem_read`.
  - Required: `mem_address` = 0x60; `inst_resp` is one pulse with `inst_rdata` = 0x00A00093; `data_resp` stays 0.
- Lone store:
  - Stimulus: `data_write` = 1, addr 0x104, wdata 0xDEADBEEF, wmask 4'b0011.
  - Required: `mem_write` = 1, `mem_wmask` = 4'b0011, `mem_wdata` = 0xDEADBEEF; `data_resp` is one pulse; `mem_read` stays 0 throughout.
- Simultaneous after reset:
  - Stimulus: `inst_read` and `data_read` both high, immediate `mem_resp`.
  - Required: D is served first, then I. A further tie is granted D again (alternation), giving grant order D, I, D, I.
- Address change mid-access:
  - Stimulus: `inst_address` changes from 0x60 to 0x64 while in SERVE_I.
  - Required: `mem_address` stays 0x60 until `mem_resp`.
- Spurious response and illegal request:
  - `mem_resp` pulse in IDLE: no resp output, state stays IDLE.
  - `data_read` = `data_write` = 1: a write is issued.
- Reset mid-access:
  - Stimulus: drop `rst_n` during SERVE_D with `mem_resp` pending.
  - Required: all outputs are 0 asynchronously; after release, the next request is granted normally with `last_grant` = 0.
